// File: rtl/if_id_queue.sv
// IF/ID boundary queue.
//
// A DEPTH-entry FIFO of (pc, inst) pairs in front of a registered ID-side
// output stage. Fetch keeps pushing while decode is stalled until the queue
// fills. With an empty queue and no stall, the fetched word goes straight
// into the output stage, so the unstalled timing is that of a plain pipeline
// register. Flush drops everything (queue and output stage).
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   rst       synchronous reset, active-high
//   stall     ctrl stall vector; only stall[STALL_IDX] is used
//   flush     discard all queued and output-stage contents
//   if_valid  fetch presents a valid pc/inst this cycle
//   if_pc     fetched instruction address
//   if_inst   fetched instruction
//   if_ready  queue can accept (count < DEPTH), from the count register only
//   id_valid  id_pc/id_inst hold a real instruction
//   id_pc     instruction address to decode
//   id_inst   instruction to decode
//   count     queue occupancy, output stage excluded
module if_id_queue #(
  parameter int unsigned AW        = 32,
  parameter int unsigned IW        = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned STALL_IDX = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [5:0]                     stall,
  input  logic                           flush,
  input  logic                           if_valid,
  input  logic [AW-1:0]                  if_pc,
  input  logic [IW-1:0]                  if_inst,
  output logic                           if_ready,
  output logic                           id_valid,
  output logic [AW-1:0]                  id_pc,
  output logic [IW-1:0]                  id_inst,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [AW-1:0] pc_mem_q   [DEPTH];
  logic [IW-1:0] inst_mem_q [DEPTH];

  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          id_valid_q;
  logic [AW-1:0] id_pc_q;
  logic [IW-1:0] id_inst_q;

  logic push, adv, pop, bypass, wr;
  logic unused_stall;

  assign unused_stall = ^stall;

  // Ready depends only on the registered count: no path from fetch inputs.
  assign if_ready = (count_q < CW'(DEPTH));

  always_comb begin
    push   = if_valid & if_ready & ~flush;
    adv    = ~stall[STALL_IDX];
    pop    = adv & (count_q != '0);
    // Bypass only when the queue is empty, so program order is preserved.
    bypass = adv & (count_q == '0) & push;
    wr     = push & ~bypass;
  end

  // Storage is deliberately not reset; pointers and count guard it.
  always_ff @(posedge clk) begin
    if (!rst && wr) begin
      pc_mem_q[wr_ptr_q]   <= if_pc;
      inst_mem_q[wr_ptr_q] <= if_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_inst_q  <= '0;
    end else begin
      if (wr) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_q + CW'(wr) - CW'(pop);

      // Stalled: the output stage holds everything, including id_valid.
      if (adv) begin
        if (pop) begin
          id_valid_q <= 1'b1;
          id_pc_q    <= pc_mem_q[rd_ptr_q];
          id_inst_q  <= inst_mem_q[rd_ptr_q];
        end else if (bypass) begin
          id_valid_q <= 1'b1;
          id_pc_q    <= if_pc;
          id_inst_q  <= if_inst;
        end else begin
          id_valid_q <= 1'b0;
          id_pc_q    <= '0;
          id_inst_q  <= '0;
        end
      end
    end
  end

  assign id_valid = id_valid_q;
  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;
  assign count    = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [5:0] NS = 6'b000000;
  localparam logic [5:0] ST = 6'b000010;

  logic        clk = 1'b0;
  logic        rst, flush, if_valid;
  logic [5:0]  stall;
  logic [31:0] if_pc, if_inst;
  logic        if_ready, id_valid;
  logic [31:0] id_pc, id_inst;
  logic [2:0]  count;

  if_id_queue #(
    .AW(32), .IW(32), .DEPTH(DEPTH), .STALL_IDX(1)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .if_ready(if_ready), .id_valid(id_valid), .id_pc(id_pc),
    .id_inst(id_inst), .count(count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: queue of accepted-but-not-yet-presented words plus the
  // expected output stage.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;
  ent_t        sb[$];
  logic        m_v;
  logic [31:0] m_pc, m_inst;
  int          n_acc, n_out;

  typedef struct {
    logic        r;
    logic [5:0]  s;
    logic        f;
    logic        v;
    logic [31:0] pc;
    logic        ev;
    logic [31:0] epc;
    int          ecnt;
    logic        erdy;
  } vec_t;
  vec_t tv[$];

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'h3401_0000 + pc * 17;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, advance the model, compare after the edge.
  task automatic step(input logic r, input logic [5:0] s, input logic f, input logic v,
                      input logic [31:0] pc);
    bit   accept;
    ent_t e;
    accept   = v && !f && (sb.size() < DEPTH);
    rst      = r;
    stall    = s;
    flush    = f;
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst_of(pc);
    @(posedge clk);
    #1;
    if (r || f) begin
      sb.delete();
      m_v = 1'b0; m_pc = '0; m_inst = '0;
    end else begin
      if (accept) begin
        sb.push_back('{pc, inst_of(pc)});
        n_acc++;
      end
      if (!s[1]) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          m_v = 1'b1; m_pc = e.pc; m_inst = e.inst;
          n_out++;
        end else begin
          m_v = 1'b0; m_pc = '0; m_inst = '0;
        end
      end
    end
    chk("id_valid", {31'b0, id_valid}, {31'b0, m_v});
    chk("id_pc", id_pc, m_pc);
    chk("id_inst", id_inst, m_inst);
    chk("count", {29'b0, count}, sb.size());
    chk("if_ready", {31'b0, if_ready}, {31'b0, sb.size() < DEPTH});
  endtask

  initial begin
    rst = 1'b1; stall = NS; flush = 1'b0; if_valid = 1'b0;
    if_pc = '0; if_inst = '0;
    m_v = 1'b0; m_pc = '0; m_inst = '0;
    n_acc = 0; n_out = 0;

    //           r  stall f  v  pc            ev epc           cnt rdy
    // reset with fetch active
    tv.push_back('{1, NS, 0, 1, 32'h200, 0, 32'h0,   0, 1});
    tv.push_back('{1, NS, 0, 1, 32'h204, 0, 32'h0,   0, 1});
    tv.push_back('{0, NS, 0, 0, 32'h0,   0, 32'h0,   0, 1});
    // bypass
    tv.push_back('{0, NS, 0, 1, 32'h100, 1, 32'h100, 0, 1});
    // stall fill to full, extra push ignored
    tv.push_back('{0, ST, 0, 1, 32'h104, 1, 32'h100, 1, 1});
    tv.push_back('{0, ST, 0, 1, 32'h108, 1, 32'h100, 2, 1});
    tv.push_back('{0, ST, 0, 1, 32'h10C, 1, 32'h100, 3, 1});
    tv.push_back('{0, ST, 0, 1, 32'h110, 1, 32'h100, 4, 0});
    tv.push_back('{0, ST, 0, 1, 32'h114, 1, 32'h100, 4, 0});
    // drain then bubble
    tv.push_back('{0, NS, 0, 0, 32'h0,   1, 32'h104, 3, 1});
    tv.push_back('{0, NS, 0, 0, 32'h0,   1, 32'h108, 2, 1});
    tv.push_back('{0, NS, 0, 0, 32'h0,   1, 32'h10C, 1, 1});
    tv.push_back('{0, NS, 0, 0, 32'h0,   1, 32'h110, 0, 1});
    tv.push_back('{0, NS, 0, 0, 32'h0,   0, 32'h0,   0, 1});
    // build count=2 under stall, then push+pop steady state
    tv.push_back('{0, ST, 0, 1, 32'h200, 0, 32'h0,   1, 1});
    tv.push_back('{0, ST, 0, 1, 32'h204, 0, 32'h0,   2, 1});
    tv.push_back('{0, NS, 0, 1, 32'h208, 1, 32'h200, 2, 1});
    tv.push_back('{0, NS, 0, 1, 32'h20C, 1, 32'h204, 2, 1});
    tv.push_back('{0, NS, 0, 1, 32'h210, 1, 32'h208, 2, 1});
    tv.push_back('{0, NS, 0, 1, 32'h214, 1, 32'h20C, 2, 1});
    // count=3 under stall, flush with push
    tv.push_back('{0, ST, 0, 1, 32'h218, 1, 32'h20C, 3, 1});
    tv.push_back('{0, ST, 1, 1, 32'h21C, 0, 32'h0,   0, 1});
    tv.push_back('{0, NS, 0, 0, 32'h0,   0, 32'h0,   0, 1});
    tv.push_back('{0, NS, 0, 1, 32'h300, 1, 32'h300, 0, 1});
    tv.push_back('{0, NS, 0, 0, 32'h0,   0, 32'h0,   0, 1});
    // reset beats flush and push
    tv.push_back('{0, NS, 0, 1, 32'h304, 1, 32'h304, 0, 1});
    tv.push_back('{1, ST, 1, 1, 32'h308, 0, 32'h0,   0, 1});

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].r, tv[i].s, tv[i].f, tv[i].v, tv[i].pc);
      chk($sformatf("tv%0d_valid", i), {31'b0, id_valid}, {31'b0, tv[i].ev});
      chk($sformatf("tv%0d_pc", i), id_pc, tv[i].epc);
      chk($sformatf("tv%0d_inst", i), id_inst, tv[i].ev ? inst_of(tv[i].epc) : 32'h0);
      chk($sformatf("tv%0d_count", i), {29'b0, count}, tv[i].ecnt);
      chk($sformatf("tv%0d_ready", i), {31'b0, if_ready}, {31'b0, tv[i].erdy});
    end

    // Wrap-around: 3 pushes under stall, 3 pops, 5 rounds.
    n_acc = 0; n_out = 0;
    step(0, NS, 0, 0, 32'h0);
    for (int rnd = 0; rnd < 5; rnd++) begin
      for (int k = 0; k < 3; k++)
        step(0, ST, 0, 1, 32'h1000 + 32'((rnd * 3 + k) * 4));
      for (int k = 0; k < 3; k++)
        step(0, NS, 0, 0, 32'h0);
    end
    step(0, NS, 0, 0, 32'h0);
    chk("wrap_in_out", n_out, n_acc);
    chk("wrap_accepted", n_acc, 15);

    // Random traffic including unused stall bits and rare flushes.
    for (int i = 0; i < 400; i++) begin
      logic [5:0] s;
      s = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) s[1] = 1'b0;
      step(0, s, ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
           32'h4000 + 32'(i * 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
